// File: rtl/mem_image_reader_if.sv
// Signal bundle for mem_image_reader: dump control, memory read bus and output byte stream.
// Valid/ready handshake (request and stream): a transfer happens on a clock edge where valid && ready;
// once valid rises, the source holds valid and its payload stable until that edge; ready may change freely.
interface mem_image_reader_if #(
    parameter int ADDR_WIDTH  = 21,
    parameter int COUNT_WIDTH = 21
);
    logic                   start;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [COUNT_WIDTH-1:0] byte_count;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [ADDR_WIDTH-1:0]  mem_req_addr;
    logic                   mem_resp_valid;
    logic [63:0]            mem_resp_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_data;
    logic                   out_last;
    logic [2:0]             state_dbg;

    modport master (
        input  start, base_addr, byte_count, mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
        output busy, done, error, mem_req_valid, mem_req_addr, out_valid, out_data, out_last, state_dbg
    );

    modport slave (
        output start, base_addr, byte_count, mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
        input  busy, done, error, mem_req_valid, mem_req_addr, out_valid, out_data, out_last, state_dbg
    );
endinterface

// File: rtl/mem_image_reader.sv
// Reads a contiguous memory region one 64-bit word at a time and streams it out as bytes.
// One read outstanding at a time; every output is a flop.
module mem_image_reader #(
    parameter int ADDR_WIDTH     = 21,
    parameter int COUNT_WIDTH    = 21,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic               clk,
    input logic               rst_n,
    mem_image_reader_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_RESP, EMIT, FINISH} state_t;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d, rem_nx;
    logic [2:0]             idx_q, idx_d, idx_nx;
    logic [63:0]            buf_q, buf_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic                   busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic                   req_valid_q, req_valid_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [7:0]             out_data_q, out_data_d;
    logic                   unused_addr_lsbs;

    // Start addresses are always word aligned; the low bits carry no meaning.
    assign unused_addr_lsbs = ^bus.base_addr[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            idx_q       <= '0;
            buf_q       <= '0;
            tcnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            req_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            tcnt_q      <= tcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            req_valid_q <= req_valid_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        tcnt_d      = tcnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        req_valid_d = req_valid_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        idx_nx      = idx_q + 3'd1;
        rem_nx      = rem_q - COUNT_WIDTH'(1);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (bus.byte_count != '0) begin
                        addr_d      = {bus.base_addr[ADDR_WIDTH-1:3], 3'b000};
                        rem_d       = bus.byte_count;
                        req_valid_d = 1'b1;
                        state_d     = REQ;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    req_valid_d = 1'b0;
                    addr_d      = addr_q + ADDR_WIDTH'(8);
                    tcnt_d      = '0;
                    state_d     = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (bus.mem_resp_valid) begin
                    buf_d       = bus.mem_resp_data;
                    idx_d       = 3'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = bus.mem_resp_data[7:0];
                    out_last_d  = (rem_q == COUNT_WIDTH'(1));
                    state_d     = EMIT;
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            EMIT: begin
                // out_valid is always high here, so out_ready alone marks a transfer.
                if (bus.out_ready) begin
                    rem_d = rem_nx;
                    idx_d = idx_nx;
                    if (rem_q == COUNT_WIDTH'(1)) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = FINISH;
                    end else if (idx_q == 3'd7) begin
                        out_valid_d = 1'b0;
                        req_valid_d = 1'b1;
                        state_d     = REQ;
                    end else begin
                        out_data_d = buf_q[{idx_nx, 3'b000} +: 8];
                        out_last_d = (rem_nx == COUNT_WIDTH'(1));
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_last      = out_last_q;
    assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_mem_image_reader.sv
// Directed bench for mem_image_reader: memory responder, ready drivers, a byte/address
// scoreboard fed from a memory-image model, and literal checks on timing and data.
module tb_mem_image_reader;
    localparam int AW = 21;
    localparam int CW = 21;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_image_reader_if #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus_if ();
    mem_image_reader #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if)
    );

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    int hs_edge = 0;
    int end_edge = 0;
    logic [7:0]    exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    got_bytes[$];
    logic [AW-1:0] got_req[$];
    logic [63:0]   mem[int];
    bit            resp_enable = 1'b1;
    int            resp_lat = 0;
    int            req_delay = 0;
    int            req_wait = 0;
    logic [3:0]    rdy_pat = 4'hF;
    int            pidx = 0;
    int            stray_req = 0;
    int            stray_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 64'hA5A5_0000_0000_0000 | 64'(a);
    endfunction

    function automatic logic [7:0] model_byte(input logic [AW-1:0] a);
        logic [63:0] w;
        w = mem_rd({a[AW-1:3], 3'b000});
        return w[{a[2:0], 3'b000} +: 8];
    endfunction

    // A dump is the byte image starting at the aligned base, fetched one word per request.
    task automatic model_dump(input logic [AW-1:0] base, input logic [CW-1:0] cnt);
        logic [AW-1:0] ab;
        ab = {base[AW-1:3], 3'b000};
        for (int i = 0; i < int'(cnt); i++) exp_q.push_back(model_byte(ab + AW'(i)));
        for (int w = 0; w * 8 < int'(cnt); w++) exp_addr_q.push_back(ab + AW'(8 * w));
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        bus_if.mem_req_ready = 1'b0;
        bus_if.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.out_ready = rdy_pat[pidx % 4];
            pidx++;
            bus_if.mem_req_ready = bus_if.mem_req_valid && (req_wait >= req_delay);
            if (bus_if.mem_req_valid) req_wait++;
            else req_wait = 0;
        end
    end

    initial begin : responder
        logic [AW-1:0] a;
        bus_if.mem_resp_valid = 1'b0;
        bus_if.mem_resp_data = '0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_done) begin
                stray_done++;
                @(posedge clk);
                #1 bus_if.mem_resp_valid = 1'b1;
                bus_if.mem_resp_data = 64'hDEAD_BEEF_0BAD_F00D;
                @(posedge clk);
                #1 bus_if.mem_resp_valid = 1'b0;
            end else if (rst_n && bus_if.mem_req_valid && bus_if.mem_req_ready && resp_enable) begin
                a = bus_if.mem_req_addr;
                @(posedge clk);
                repeat (resp_lat) @(posedge clk);
                #1 bus_if.mem_resp_valid = 1'b1;
                bus_if.mem_resp_data = mem_rd(a);
                @(posedge clk);
                #1 bus_if.mem_resp_valid = 1'b0;
            end
        end
    end

    initial begin : scoreboard
        logic       prev_ov, prev_or, prev_rv, prev_rr;
        logic [7:0] prev_od;
        logic [AW-1:0] prev_ra;
        logic [7:0] e;
        logic [AW-1:0] ea;
        prev_ov = 0; prev_or = 0; prev_rv = 0; prev_rr = 0; prev_od = 0; prev_ra = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 0;
                prev_rv = 0;
            end else begin
                if (prev_ov && !prev_or) begin
                    check("hold_out_valid", bus_if.out_valid, 1);
                    check("hold_out_data", bus_if.out_data, prev_od);
                end
                if (prev_rv && !prev_rr) begin
                    check("hold_req_valid", bus_if.mem_req_valid, 1);
                    check("hold_req_addr", bus_if.mem_req_addr, prev_ra);
                end
                if (bus_if.out_valid && bus_if.out_ready) begin
                    got_bytes.push_back(bus_if.out_data);
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_byte: got %0h required no byte", bus_if.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_byte", bus_if.out_data, e);
                        check("stream_last", bus_if.out_last, exp_q.size() == 0);
                    end
                end
                if (bus_if.mem_req_valid && bus_if.mem_req_ready) begin
                    got_req.push_back(bus_if.mem_req_addr);
                    hs_edge = cyc_cnt + 1;
                    if (exp_addr_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req: got %0h required no request", bus_if.mem_req_addr);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("req_addr", bus_if.mem_req_addr, ea);
                    end
                end
                prev_ov = bus_if.out_valid; prev_or = bus_if.out_ready; prev_od = bus_if.out_data;
                prev_rv = bus_if.mem_req_valid; prev_rr = bus_if.mem_req_ready; prev_ra = bus_if.mem_req_addr;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus_if.busy, 0);
        check({tag, "_done"}, bus_if.done, 0);
        check({tag, "_error"}, bus_if.error, 0);
        check({tag, "_req_valid"}, bus_if.mem_req_valid, 0);
        check({tag, "_req_addr"}, bus_if.mem_req_addr, 0);
        check({tag, "_out_valid"}, bus_if.out_valid, 0);
        check({tag, "_out_data"}, bus_if.out_data, 0);
        check({tag, "_out_last"}, bus_if.out_last, 0);
        check({tag, "_state"}, bus_if.state_dbg, 0);
    endtask

    task automatic run_dump(input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                            output int lat, output bit sd, output bit se);
        bit   seen;
        logic pb;
        model_dump(base, cnt);
        bus_if.base_addr = base;
        bus_if.byte_count = cnt;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
        lat = 0; seen = 0; pb = 0; sd = 0; se = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus_if.done || bus_if.error) seen = 1;
            else begin
                pb = bus_if.busy;
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL dump_end: no done/error after %0d cycles, required within 600", lat);
        end else begin
            end_edge = cyc_cnt;
            sd = bus_if.done;
            se = bus_if.error;
            check("busy_at_end", bus_if.busy, 0);
            check("busy_before_end", pb, 1);
            @(posedge clk);
            #1;
            @(negedge clk);
            check("done_one_cycle", bus_if.done, 0);
            check("error_one_cycle", bus_if.error, 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int lat, b0, r0;
        bit sd, se;
        bus_if.start = 0;
        bus_if.base_addr = '0;
        bus_if.byte_count = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two full words, streaming back to back.
        mem[32'h1000] = 64'h0706050403020100;
        mem[32'h1008] = 64'h0F0E0D0C0B0A0908;
        b0 = got_bytes.size(); r0 = got_req.size();
        run_dump(21'h1000, 16, lat, sd, se);
        check("s1_done", sd, 1);
        check("s1_error", se, 0);
        check("s1_latency", lat, 22);
        check("s1_nbytes", got_bytes.size() - b0, 16);
        check("s1_nreq", got_req.size() - r0, 2);
        if (got_bytes.size() - b0 == 16) begin
            check("s1_first_byte", got_bytes[b0], 8'h00);
            check("s1_last_byte", got_bytes[b0 + 15], 8'h0F);
        end
        if (got_req.size() - r0 == 2) begin
            check("s1_req0", got_req[r0], 21'h1000);
            check("s1_req1", got_req[r0 + 1], 21'h1008);
        end

        // Unaligned base, partial word.
        mem[32'h1000] = 64'h8877665544332211;
        b0 = got_bytes.size(); r0 = got_req.size();
        run_dump(21'h1005, 3, lat, sd, se);
        check("s2_done", sd, 1);
        check("s2_latency", lat, 7);
        check("s2_nreq", got_req.size() - r0, 1);
        check("s2_nbytes", got_bytes.size() - b0, 3);
        if (got_bytes.size() - b0 == 3) begin
            check("s2_b0", got_bytes[b0], 8'h11);
            check("s2_b1", got_bytes[b0 + 1], 8'h22);
            check("s2_b2", got_bytes[b0 + 2], 8'h33);
        end
        if (got_req.size() - r0 == 1) check("s2_req0", got_req[r0], 21'h1000);

        // Zero-length dump.
        b0 = got_bytes.size(); r0 = got_req.size();
        run_dump(21'h3000, 0, lat, sd, se);
        check("s3_done", sd, 1);
        check("s3_latency", lat, 2);
        check("s3_nbytes", got_bytes.size() - b0, 0);
        check("s3_nreq", got_req.size() - r0, 0);

        // Back-pressure on both sides.
        mem[32'h1000] = 64'h0706050403020100;
        rdy_pat = 4'b1001;
        req_delay = 3;
        resp_lat = 2;
        b0 = got_bytes.size(); r0 = got_req.size();
        run_dump(21'h1000, 16, lat, sd, se);
        check("s4_done", sd, 1);
        check("s4_nbytes", got_bytes.size() - b0, 16);
        check("s4_nreq", got_req.size() - r0, 2);
        check("s4_left", exp_q.size(), 0);
        rdy_pat = 4'hF;
        req_delay = 0;
        resp_lat = 0;

        // No response: timeout.
        resp_enable = 1'b0;
        run_dump(21'h2000, 8, lat, sd, se);
        check("s5_error", se, 1);
        check("s5_no_done", sd, 0);
        check("s5_err_latency", end_edge - hs_edge, TO);
        check("s5_state_idle", bus_if.state_dbg, 0);
        exp_q.delete();
        exp_addr_q.delete();
        resp_enable = 1'b1;
        b0 = got_bytes.size();
        run_dump(21'h1000, 8, lat, sd, se);
        check("s5_restart_done", sd, 1);
        check("s5_restart_nbytes", got_bytes.size() - b0, 8);

        // Reset in the middle of streaming, then a stray response.
        mem[32'h1000] = 64'h0706050403020100;
        b0 = got_bytes.size();
        model_dump(21'h1000, 16);
        bus_if.base_addr = 21'h1000;
        bus_if.byte_count = 16;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
        for (int i = 0; i < 100 && got_bytes.size() < b0 + 3; i++) @(negedge clk);
        check("s6_mid_emit", bus_if.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("s6_async");
        exp_q.delete();
        exp_addr_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        stray_req++;
        repeat (5) @(posedge clk);
        #1;
        check("s6_stray_out_valid", bus_if.out_valid, 0);
        check("s6_stray_state", bus_if.state_dbg, 0);
        check("s6_stray_busy", bus_if.busy, 0);
        b0 = got_bytes.size();
        run_dump(21'h1000, 16, lat, sd, se);
        check("s6_again_done", sd, 1);
        check("s6_again_latency", lat, 22);
        check("s6_again_nbytes", got_bytes.size() - b0, 16);

        // Address wrap at the top of memory.
        r0 = got_req.size();
        run_dump(21'h1FFFF8, 16, lat, sd, se);
        check("s7_done", sd, 1);
        check("s7_nreq", got_req.size() - r0, 2);
        if (got_req.size() - r0 == 2) begin
            check("s7_req0", got_req[r0], 21'h1FFFF8);
            check("s7_req1", got_req[r0 + 1], 21'h000000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_image_reader.md
Name: mem_image_reader

Overview:
- Bus-initiator block that reads a contiguous region of global memory over the core memory bus and emits it as a byte stream.
- It is the read-back counterpart of the image loader. The loader writes the code and data segments into memory. This block streams a segment, for example the data segment after a run, out to a checker or dump sink.
- It sits beside the fetch and vector-access ports on the internal memory multiplexer. It has one outstanding read at a time.

Parameters:
- ADDR_WIDTH, 21, physical byte-address width (matches phys_memory_address_t).
- COUNT_WIDTH, 21, width of the byte-count input.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for a read response before aborting with error.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  start byte address; bits [2:0] ignored (treated as 0).
- byte_count  in  COUNT_WIDTH  number of bytes to emit.
- busy  out  1  high from the cycle after an accepted start until done/error.
- done  out  1  one-cycle pulse on normal completion.
- error  out  1  one-cycle pulse on response timeout.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  bus accepts the request when valid&&ready.
- mem_req_addr  out  ADDR_WIDTH  8-byte-aligned word address of the request.
- mem_resp_valid  in  1  read data valid, one cycle.
- mem_resp_data  in  64  read data, byte 0 in bits [7:0] (little-endian).
- out_valid  out  1  stream byte valid.
- out_ready  in  1  sink accepts the byte when out_valid&&out_ready.
- out_data  out  8  stream byte.
- out_last  out  1  high with the final byte of the dump.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy, done, error, mem_req_valid, out_valid, out_last = 0.
  - mem_req_addr, out_data = 0.
  - Counters are cleared.
  - Any in-flight response is discarded, including across reset release.
- States: IDLE, REQ, WAIT_RESP, EMIT, FINISH.
- IDLE:
  - start=1 with byte_count>0: latch {base_addr[ADDR_WIDTH-1:3],3'b0} into the address register and byte_count into the remaining counter. Go to REQ; busy=1 next cycle.
  - start=1 with byte_count=0: go to FINISH without issuing any request.
- REQ:
  - mem_req_valid=1 and mem_req_addr=address register.
  - Hold both stable until mem_req_ready.
  - On the handshake cycle, go to WAIT_RESP, clear the timeout counter, and add 8 to the address (wraps modulo 2^ADDR_WIDTH).
- WAIT_RESP:
  - mem_resp_valid=1: capture the 64-bit word into the shift buffer and go to EMIT with byte index 0.
  - Otherwise increment the timeout counter. On reaching TIMEOUT_CYCLES, pulse error for one cycle, drop busy, and return to IDLE. done is not pulsed.
- EMIT:
  - out_valid=1 and out_data=buffer byte[index].
  - On out_valid&&out_ready: decrement remaining and increment index.
  - If remaining becomes 0 → FINISH. out_last was high on that byte.
  - Else if index was 7 → REQ.
  - out_data and out_valid are held stable while out_ready=0.
- FINISH: done=1 for exactly one cycle, busy=0, then IDLE.
- Ignored inputs:
  - start is ignored in every state except IDLE.
  - mem_resp_valid is ignored outside WAIT_RESP.
- Latency: the first byte is valid 1 cycle after the response cycle. Minimum per 8-byte word is 1 (REQ) + bus latency + 8 EMIT cycles with out_ready held high.
- Partial final word: only the remaining bytes (1-7) are emitted; the upper bytes are discarded.
- Outputs are registered; no combinational path from out_ready to out_valid.

Test Plan:
- Reset, then start with base_addr=0x1000, byte_count=16, memory words 0x0706050403020100 and 0x0F0E0D0C0B0A0908, out_ready=1 → requests at 0x1000 then 0x1008. Bytes 0x00..0x0F in order. out_last on 0x0F. done pulse one cycle after. busy falls with done.
- base_addr=0x1005, byte_count=3, word 0x8877665544332211 → one request at 0x1000. Output 0x11, 0x22, 0x33. out_last on 0x33. No second request.
- byte_count=0 → no mem_req_valid, done pulses 2 cycles after start, no output bytes.
- out_ready toggled 1,0,0,1 during EMIT and mem_req_ready delayed 3 cycles → out_data and mem_req_addr held stable. No byte duplicated or lost. Exactly byte_count handshakes.
- TIMEOUT_CYCLES=8, bus never responds → error pulse 8 cycles after the request handshake, no done, state IDLE. A new start is accepted next cycle.
- rst_n asserted mid-EMIT, then a response arriving after release → all outputs 0 immediately. The late response is ignored. The next start behaves as in the first scenario.
- base_addr=0x1FFFF8, byte_count=16 → second request at 0x000000 (address wrap).
